// File: rtl/bram_stream_reader.sv
// Sweeps a 2^HLEN-word BRAM and streams it out over valid/ready with a 2-entry skid buffer.
// Optional BITREV_OUT_EN: read addresses are the bit-reverse of the sweep index.
module bram_stream_reader #(
    parameter int DLEN = 32,
    parameter int HLEN = 9
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [HLEN-1:0] raddr_o,
    output logic            rd_en_o,
    input  logic [DLEN-1:0] rdata_i,
    output logic            m_valid_o,
    input  logic            m_ready_i,
    output logic [DLEN-1:0] m_data_o,
    output logic            m_last_o
);

    localparam logic [HLEN:0]   N_WORDS   = (HLEN+1)'(1) << HLEN;
    localparam logic [HLEN-1:0] LAST_BEAT = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q, state_d;
    logic [HLEN:0]   k_q, k_d;
    logic [HLEN-1:0] b_q, b_d;
    logic [1:0]      cnt_q, cnt_d;
    logic            inflight_q, inflight_d;
    logic            done_q, done_d;
    logic [HLEN-1:0] raddr_q;
    logic [DLEN-1:0] fifo_q [2];
    logic            rd_ptr_q, wr_ptr_q;

    logic            pop, push, issue, last_pop;
    logic [2:0]      occ;
    logic [HLEN-1:0] addr_k;

    function automatic logic [HLEN-1:0] bitrev(input logic [HLEN-1:0] v);
        logic [HLEN-1:0] r;
        for (int i = 0; i < HLEN; i++) begin
            r[i] = v[HLEN-1-i];
        end
        return r;
    endfunction

`ifdef BITREV_OUT_EN
    assign addr_k = bitrev(k_q[HLEN-1:0]);
`else
    assign addr_k = k_q[HLEN-1:0];
`endif

    assign m_valid_o = (cnt_q != 2'd0);
    assign pop       = m_valid_o & m_ready_i;
    assign push      = inflight_q;
    assign occ       = {1'b0, cnt_q} + {2'b00, inflight_q};
    // Issue only if the word still fits after this cycle's pop: buffer + in flight never exceeds 2.
    assign issue     = (state_q == RUN) && (k_q < N_WORDS) && ((occ - {2'b00, pop}) < 3'd2);
    assign last_pop  = pop & (b_q == LAST_BEAT);

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        b_d        = b_q;
        done_d     = 1'b0;
        inflight_d = issue;
        cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = RUN;
                    k_d     = '0;
                    b_d     = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    k_d = k_q + 1'b1;
                end
                if (pop) begin
                    b_d = b_q + 1'b1;
                end
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            k_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
            raddr_q    <= '0;
            fifo_q[0]  <= '0;
            fifo_q[1]  <= '0;
            rd_ptr_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
            if (issue) begin
                raddr_q <= addr_k;
            end
            if (push) begin
                fifo_q[wr_ptr_q] <= rdata_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign busy_o   = (state_q == RUN);
    assign done_o   = done_q;
    assign rd_en_o  = issue;
    assign raddr_o  = issue ? addr_k : raddr_q;
    assign m_data_o = fifo_q[rd_ptr_q];
    assign m_last_o = m_valid_o & (b_q == LAST_BEAT);

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized scoreboard bench for bram_stream_reader with HLEN=3 and a behavioural BRAM.
module tb_bram_stream_reader;

    localparam int DLEN = 32;
    localparam int HLEN = 3;
    localparam int N    = 1 << HLEN;

    logic            clk = 1'b0;
    logic            reset_i, start_i, m_ready_i;
    logic            busy_o, done_o, rd_en_o, m_valid_o, m_last_o;
    logic [HLEN-1:0] raddr_o;
    logic [DLEN-1:0] rdata_i, m_data_o;
    logic [DLEN-1:0] mem [N];

    bram_stream_reader #(.DLEN(DLEN), .HLEN(HLEN)) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .start_i  (start_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .raddr_o  (raddr_o),
        .rd_en_o  (rd_en_o),
        .rdata_i  (rdata_i),
        .m_valid_o(m_valid_o),
        .m_ready_i(m_ready_i),
        .m_data_o (m_data_o),
        .m_last_o (m_last_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rdata_i <= mem[raddr_o];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Sweep index j reads address j, or bit-reversed j when the option is built in.
    function automatic int ref_addr(input int j);
        int r;
        r = j;
`ifdef BITREV_OUT_EN
        r = 0;
        for (int i = 0; i < HLEN; i++) begin
            if ((j >> i) & 1) r = r | (1 << (HLEN - 1 - i));
        end
`endif
        return r;
    endfunction

    typedef struct {
        logic [DLEN-1:0] data;
        logic            last;
    } beat_t;

    beat_t           exp_q [$];
    bit              in_sweep    = 0;
    bit              done_exp    = 0;
    bit              chk_rst     = 0;
    bit              stall_prev  = 0;
    logic [DLEN-1:0] prev_data   = '0;
    logic            prev_last   = 1'b0;
    int              rel         = 0;
    int              iss         = 0;
    int              pops        = 0;
    int              done_cnt    = 0;
    int              last_done_rel = -1;

    always @(negedge clk) begin
        if (reset_i) begin
            exp_q.delete();
            in_sweep   = 0;
            done_exp   = 0;
            stall_prev = 0;
            chk_rst    = 1;
            iss        = 0;
            pops       = 0;
        end else begin
            beat_t b;
            bit    hs;
            rel++;
            if (chk_rst) begin
                chk("rst_busy", busy_o, 0);
                chk("rst_done", done_o, 0);
                chk("rst_raddr", raddr_o, 0);
                chk("rst_rd_en", rd_en_o, 0);
                chk("rst_m_valid", m_valid_o, 0);
                chk("rst_m_data", m_data_o, 0);
                chk("rst_m_last", m_last_o, 0);
                chk_rst = 0;
            end
            chk("busy", busy_o, in_sweep);
            chk("done", done_o, done_exp);
            if (done_o) begin
                done_cnt++;
                last_done_rel = rel;
            end
            done_exp = 0;
            if (!in_sweep) chk("rd_en_idle", rd_en_o, 0);
            if (in_sweep && rel == 1) chk("first_issue", rd_en_o, 1);
            if (in_sweep && rel == 2) chk("valid_c2", m_valid_o, 0);
            if (in_sweep && rel == 3) chk("valid_c3", m_valid_o, 1);
            if (rd_en_o) begin
                chk("issue_in_range", iss < N, 1);
                chk("raddr", raddr_o, ref_addr(iss));
                iss++;
            end
            if (stall_prev) begin
                chk("stall_valid", m_valid_o, 1);
                chk("stall_data", m_data_o, prev_data);
                chk("stall_last", m_last_o, prev_last);
            end
            hs = m_valid_o && m_ready_i;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    b = exp_q.pop_front();
                    chk("m_data", m_data_o, b.data);
                    chk("m_last", m_last_o, b.last);
                    pops++;
                    if (b.last) begin
                        done_exp = 1;
                        in_sweep = 0;
                    end
                end
            end
            if (in_sweep) chk("outstanding_le_2", (iss - pops) <= 2, 1);
            stall_prev = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
            if (start_i && !busy_o) begin
                for (int j = 0; j < N; j++) begin
                    b.data = mem[ref_addr(j)];
                    b.last = (j == N - 1);
                    exp_q.push_back(b);
                end
                in_sweep = 1;
                rel      = 0;
                iss      = 0;
                pops     = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: ready toggling (with a stray start), 2: random ready and starts
    task automatic wait_done(input int mode, input int bound);
        int d0;
        int t;
        bit tg;
        d0 = done_cnt;
        t  = 0;
        tg = 1;
        while (done_cnt == d0 && t < bound) begin
            case (mode)
                0: m_ready_i = 1'b1;
                1: begin
                    m_ready_i = tg;
                    tg = !tg;
                end
                default: m_ready_i = ($urandom_range(0, 3) != 0);
            endcase
            if (busy_o && ((mode == 1 && t == 4) || (mode == 2 && $urandom_range(0, 7) == 0)))
                start_i = 1'b1;
            tick();
            start_i = 1'b0;
            t++;
        end
        chk("sweep_done_in_time", t < bound, 1);
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        int t;
        for (int i = 0; i < N; i++) mem[i] = DLEN'(i + 100);
        reset_i   = 1'b1;
        start_i   = 1'b0;
        m_ready_i = 1'b0;
        repeat (3) tick();
        reset_i = 1'b0;
        tick();

        m_ready_i = 1'b1;
        pulse_start();
        wait_done(0, 100);
        chk("done_cycle_full_rate", last_done_rel, N + 3);
        tick();

        pulse_start();
        wait_done(1, 200);
        tick();

        m_ready_i = 1'b0;
        pulse_start();
        repeat (20) tick();
        chk("stall_issue_count", iss, 2);
        chk("stall_head_valid", m_valid_o, 1);
        chk("stall_head_data", m_data_o, mem[ref_addr(0)]);
        wait_done(0, 100);
        tick();

        m_ready_i = 1'b1;
        pulse_start();
        t = 0;
        while (!done_o && t < 100) begin
            tick();
            t++;
        end
        chk("done_seen_for_restart", done_o, 1);
        pulse_start();
        chk("restart_busy", busy_o, 1);
        chk("restart_raddr", raddr_o, ref_addr(0));
        wait_done(0, 100);
        tick();

        pulse_start();
        repeat (4) tick();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        tick();
        pulse_start();
        wait_done(0, 100);
        tick();

        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < N; i++) mem[i] = $urandom;
            pulse_start();
            wait_done(2, 400);
            tick();
        end

        chk("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
